// File: rtl/l2_event_arbiter_if.sv
// Bus bundle between the L1 spike source and the L2 event arbiter.
// Latency: none (wires only).
// Backpressure: none; lines that are already pending absorb re-pulses as counted drops.
//
// master : drives the event/enable/clear inputs and observes the arbiter outputs.
// slave  : the arbiter side.
//   i_en, i_event[p_s:1], i_clear          -> arbiter
//   o_event[p_s:1], o_valid, o_busy,
//   o_drop_cnt[p_cnt_w-1:0], o_overflow    <- arbiter
interface l2_event_arbiter_if #(
    parameter int p_s     = 10,
    parameter int p_cnt_w = 16
);
    logic               i_en;
    logic [p_s:1]       i_event;
    logic               i_clear;
    logic [p_s:1]       o_event;
    logic               o_valid;
    logic               o_busy;
    logic [p_cnt_w-1:0] o_drop_cnt;
    logic               o_overflow;

    modport master (
        output i_en, i_event, i_clear,
        input  o_event, o_valid, o_busy, o_drop_cnt, o_overflow
    );

    modport slave (
        input  i_en, i_event, i_clear,
        output o_event, o_valid, o_busy, o_drop_cnt, o_overflow
    );
endinterface

// File: rtl/l2_event_arbiter.sv
// Round-robin serialiser of L1 spikes into at most one one-hot L2 event per cycle.
// Latency: one cycle from i_event to o_event on an idle arbiter; p_gap idle cycles after each grant.
// Backpressure: none; a re-pulse on a line that is already pending and not granted is dropped and counted.
//
// Ports: i_clk, i_rst (async active-high) plain; everything else on bus (slave modport):
//   i_en gates i_event, i_clear zeroes drop count/overflow, o_event/o_valid registered grant,
//   o_busy pending/gap/valid indicator, o_drop_cnt saturating drop count, o_overflow sticky drop flag.
module l2_event_arbiter #(
    parameter int p_s     = 10,
    parameter int p_gap   = 0,
    parameter int p_cnt_w = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    l2_event_arbiter_if.slave    bus
);
    localparam int PTR_W = $clog2(p_s + 1);
    localparam int POP_W = $clog2(p_s + 1);
    localparam int GAP_W = 4;
    localparam int SUM_W = p_cnt_w + 1;

    typedef enum logic {ST_ARB, ST_GAP} state_t;

    state_t             state_q, state_d;
    logic [p_s:1]       pending_q, pending_d;
    logic [p_s:1]       event_q, event_d;
    logic               valid_q, valid_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [p_cnt_w-1:0] drop_cnt_q, drop_cnt_d;
    logic               overflow_q, overflow_d;

    logic [p_s:1]       new_ev;
    logic [p_s:1]       eligible;
    logic [p_s:1]       grant;
    logic [p_s:1]       drop;
    logic               found;
    int                 gidx;
    int                 idx;
    logic [POP_W-1:0]   drop_num;
    logic [p_cnt_w-1:0] cnt_base;
    logic [SUM_W-1:0]   cnt_sum;

    always_comb begin
        new_ev   = bus.i_en ? bus.i_event : '0;
        eligible = pending_q | new_ev;
        grant    = '0;
        found    = 1'b0;
        gidx     = 0;
        idx      = 0;

        // Rotating search starting at ptr, wrapping p_s -> 1.
        if (state_q == ST_ARB) begin
            for (int off = 0; off < p_s; off++) begin
                idx = int'(ptr_q) + off;
                if (idx > p_s) idx = idx - p_s;
                if (!found && eligible[idx]) begin
                    found       = 1'b1;
                    gidx        = idx;
                    grant[idx]  = 1'b1;
                end
            end
        end

        // A granted line keeps its pending bit only if it was already pending and
        // re-pulsed now: the old event is served, the new one is queued behind it.
        drop      = pending_q & new_ev & ~grant;
        pending_d = (grant & pending_q & new_ev) | (~grant & (pending_q | new_ev));

        event_d = grant;
        valid_d = found;

        ptr_d = ptr_q;
        if (found) ptr_d = (gidx == p_s) ? PTR_W'(1) : PTR_W'(gidx + 1);

        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            ST_ARB: begin
                if (found && p_gap != 0) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_W'(p_gap);
                end
            end
            ST_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = ST_ARB;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_ARB;
                gap_d   = '0;
            end
        endcase

        drop_num = '0;
        for (int k = 1; k <= p_s; k++) drop_num = drop_num + POP_W'(drop[k]);

        // Clear applies first so that drops in the clear cycle still register.
        cnt_base   = bus.i_clear ? '0 : drop_cnt_q;
        cnt_sum    = SUM_W'(cnt_base) + SUM_W'(drop_num);
        drop_cnt_d = cnt_sum[p_cnt_w] ? '1 : cnt_sum[p_cnt_w-1:0];
        overflow_d = (bus.i_clear ? 1'b0 : overflow_q) | (|drop);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_ARB;
            pending_q  <= '0;
            event_q    <= '0;
            valid_q    <= 1'b0;
            ptr_q      <= PTR_W'(1);
            gap_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            event_q    <= event_d;
            valid_q    <= valid_d;
            ptr_q      <= ptr_d;
            gap_q      <= gap_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.o_event    = event_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_busy     = valid_q | (|pending_q) | (state_q == ST_GAP);
    assign bus.o_drop_cnt = drop_cnt_q;
    assign bus.o_overflow = overflow_q;
endmodule

// File: tb/tb_l2_event_arbiter.sv
// Scoreboard bench: two arbiters (gap 0 and gap 2) share one stimulus stream.
// Latency: expected outputs are pushed at the driving negedge, compared #1 after the next posedge.
// Backpressure: not applicable; drops are modelled per line.
module tb_l2_event_arbiter;
    localparam int P_S = 10;
    localparam int CW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_event_arbiter_if #(.p_s(P_S), .p_cnt_w(CW)) bus_a ();
    l2_event_arbiter_if #(.p_s(P_S), .p_cnt_w(CW)) bus_b ();

    l2_event_arbiter #(.p_s(P_S), .p_gap(0), .p_cnt_w(CW)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(bus_a.slave));
    l2_event_arbiter #(.p_s(P_S), .p_gap(2), .p_cnt_w(CW)) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(bus_b.slave));

    typedef struct {
        logic [P_S:1]  ev   [2];
        logic          bsy  [2];
        logic [CW-1:0] cnt  [2];
        logic          ovf  [2];
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model state: set of waiting lines, next line to look at,
    // remaining idle cycles, and the drop statistics.
    logic [P_S:1] m_pend [2];
    int           m_ptr  [2];
    int           m_gap  [2];
    int           m_cnt  [2];
    logic         m_ovf  [2];

    function automatic int gap_of(input int n);
        return (n == 0) ? 0 : 2;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_pend[n] = '0; m_ptr[n] = 1; m_gap[n] = 0; m_cnt[n] = 0; m_ovf[n] = 1'b0;
        end
    endtask

    task automatic model_step(input int n, input logic en, input logic [P_S:1] ev, input logic clr,
                              output logic [P_S:1] oe, output logic bsy,
                              output logic [CW-1:0] cnt, output logic ovf);
        logic [P_S:1] nw;
        int g, drops, line;
        nw = en ? ev : '0;
        g = 0;
        if (m_gap[n] == 0) begin
            for (int off = 0; off < P_S && g == 0; off++) begin
                line = ((m_ptr[n] - 1 + off) % P_S) + 1;
                if (m_pend[n][line] || nw[line]) g = line;
            end
        end
        drops = 0;
        for (int k = 1; k <= P_S; k++) begin
            if (k == g) m_pend[n][k] = m_pend[n][k] & nw[k];
            else begin
                if (m_pend[n][k] && nw[k]) drops++;
                m_pend[n][k] = m_pend[n][k] | nw[k];
            end
        end
        if (g != 0) begin
            m_ptr[n] = (g == P_S) ? 1 : g + 1;
            m_gap[n] = gap_of(n);
        end else if (m_gap[n] > 0) begin
            m_gap[n]--;
        end
        if (clr) begin m_cnt[n] = 0; m_ovf[n] = 1'b0; end
        m_cnt[n] = m_cnt[n] + drops;
        if (m_cnt[n] > 65535) m_cnt[n] = 65535;
        if (drops > 0) m_ovf[n] = 1'b1;
        oe = '0;
        if (g != 0) oe[g] = 1'b1;
        bsy = (m_pend[n] != '0) || (m_gap[n] > 0) || (g != 0);
        cnt = CW'(m_cnt[n]);
        ovf = m_ovf[n];
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic [P_S:1] ev, input logic clr);
        exp_t e;
        @(negedge clk);
        bus_a.i_en = en; bus_a.i_event = ev; bus_a.i_clear = clr;
        bus_b.i_en = en; bus_b.i_event = ev; bus_b.i_clear = clr;
        for (int n = 0; n < 2; n++)
            model_step(n, en, ev, clr, e.ev[n], e.bsy[n], e.cnt[n], e.ovf[n]);
        sb.push_back(e);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, '0, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_event_a"}, 32'(bus_a.o_event), 0);
        chk({tag, "_valid_a"}, 32'(bus_a.o_valid), 0);
        chk({tag, "_busy_a"},  32'(bus_a.o_busy),  0);
        chk({tag, "_event_b"}, 32'(bus_b.o_event), 0);
        chk({tag, "_busy_b"},  32'(bus_b.o_busy),  0);
    endtask

    // Monitor: one expected record per driven cycle, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("event_a", 32'(bus_a.o_event),    32'(e.ev[0]));
                chk("valid_a", 32'(bus_a.o_valid),    32'(|e.ev[0]));
                chk("busy_a",  32'(bus_a.o_busy),     32'(e.bsy[0]));
                chk("cnt_a",   32'(bus_a.o_drop_cnt), 32'(e.cnt[0]));
                chk("ovf_a",   32'(bus_a.o_overflow), 32'(e.ovf[0]));
                chk("event_b", 32'(bus_b.o_event),    32'(e.ev[1]));
                chk("valid_b", 32'(bus_b.o_valid),    32'(|e.ev[1]));
                chk("busy_b",  32'(bus_b.o_busy),     32'(e.bsy[1]));
                chk("cnt_b",   32'(bus_b.o_drop_cnt), 32'(e.cnt[1]));
                chk("ovf_b",   32'(bus_b.o_overflow), 32'(e.ovf[1]));
            end
        end
    end

    initial begin
        logic [P_S:1] rnd;
        bus_a.i_en = 1'b0; bus_a.i_event = '0; bus_a.i_clear = 1'b0;
        bus_b.i_en = 1'b0; bus_b.i_event = '0; bus_b.i_clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        chk("reset_cnt_a", 32'(bus_a.o_drop_cnt), 0);
        chk("reset_ovf_a", 32'(bus_a.o_overflow), 0);
        rst = 1'b0;

        // Single event, then all lines at once, then a gapped pair.
        drive(1'b1, 10'b0000000100, 1'b0);
        idle(3);
        drive(1'b1, '1, 1'b0);
        idle(12);
        drive(1'b1, 10'b0000010100, 1'b0);
        idle(8);

        // Collisions: queue 1..4, re-pulse 4 during the first grant, then re-pulse each granted line.
        drive(1'b1, 10'b0000001111, 1'b0);
        drive(1'b1, 10'b0000001000, 1'b0);
        drive(1'b1, 10'b0000000010, 1'b0);
        drive(1'b0, 10'b0000000100, 1'b0);
        idle(10);
        drive(1'b0, '0, 1'b1);
        idle(2);

        // Saturate the drop counter, then clear it while nothing new arrives.
        for (int i = 0; i < 8000; i++) drive(1'b1, '1, 1'b0);
        @(posedge clk); #1;
        chk("sat_cnt_a", 32'(bus_a.o_drop_cnt), 32'h0000_FFFF);
        chk("sat_ovf_a", 32'(bus_a.o_overflow), 1);
        drive(1'b0, '0, 1'b1);
        @(posedge clk); #1;
        chk("clr_cnt_a", 32'(bus_a.o_drop_cnt), 0);
        chk("clr_ovf_a", 32'(bus_a.o_overflow), 0);
        idle(30);

        // Random traffic with occasional disable and clear.
        for (int i = 0; i < 4000; i++) begin
            rnd = P_S'($urandom & $urandom & $urandom);
            drive(($urandom_range(0, 3) != 0), rnd, ($urandom_range(0, 60) == 0));
        end

        // Reset while a burst is still draining.
        drive(1'b1, '1, 1'b0);
        idle(3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(15);
        drive(1'b1, 10'b0000100000, 1'b0);
        drive(1'b1, 10'b0000000001, 1'b0);
        idle(6);

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
